// File: rtl/scaler_h.sv
// ============================================================================
// Module   : scaler_h
// Brief    : Horizontal linear-interpolation scaler on a de/hs/vs video stream.
//            Optional overrun flag port ovf_o enabled by SCALER_H_OVF_DET_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scaler_h #(
    parameter int LINE_IN_SIZE_MAX = 1024,
    parameter int LINE_STEP        = 128,
    parameter int PIXEL_WIDTH      = 8,
    parameter int COE_WIDTH        = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            line_in_size,
    input  logic [15:0]            scale_step,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
`ifdef SCALER_H_OVF_DET_EN
    output logic                   ovf_o,
`endif
    output logic                   vs_o
);

    localparam int c_FRAC     = $clog2(LINE_STEP);
    localparam int c_CNT_W    = $clog2(LINE_IN_SIZE_MAX) + 1;
    localparam int c_COE_SH   = COE_WIDTH - c_FRAC;
    localparam int c_PROD_W   = PIXEL_WIDTH + COE_WIDTH + 1;
    localparam int c_POS_W    = ((c_CNT_W + c_FRAC) > 16 ? (c_CNT_W + c_FRAC) : 16) + 1;
    localparam int c_PIPE_LAT = 4;
    localparam logic [COE_WIDTH:0] c_ONE  = {1'b1, {COE_WIDTH{1'b0}}};
    localparam logic [c_PROD_W:0]  c_HALF = (c_PROD_W + 1)'(1) << (COE_WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LINE = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   w_line_act;

    logic                   r_hs_q;
    logic                   r_vs_q;
    logic [15:0]            r_size;
    logic [15:0]            r_step;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_POS_W-1:0]     r_pos;
    logic [PIXEL_WIDTH-1:0] r_prev;
    logic [PIXEL_WIDTH-1:0] r_cur;

    logic                   w_hs_fall;
    logic                   w_vs_fall;
    logic                   w_run;
    logic [c_CNT_W-1:0]     w_cnt_cur;
    logic [15:0]            w_size_cur;
    logic                   w_accept;
    logic [31:0]            w_k32;
    logic [31:0]            w_cnt32;
    logic [31:0]            w_size32;
    logic                   w_in_range;
    logic                   w_repl;
    logic                   w_issue;
    logic                   w_skip;
    logic [c_POS_W-1:0]     w_pos_nxt;

    logic                   r_s1_vld;
    logic [PIXEL_WIDTH-1:0] r_s1_a;
    logic [PIXEL_WIDTH-1:0] r_s1_b;
    logic [c_FRAC-1:0]      r_s1_f;
    logic [COE_WIDTH-1:0]   w_coef;
    logic [COE_WIDTH:0]     w_wa;
    logic [COE_WIDTH:0]     w_wb;
    logic                   r_s2_vld;
    logic [c_PROD_W-1:0]    r_s2_pa;
    logic [c_PROD_W-1:0]    r_s2_pb;
    logic [c_PROD_W:0]      w_sum;
    logic                   r_de;
    logic [PIXEL_WIDTH-1:0] r_do;
    logic [c_PIPE_LAT-1:0]  r_hs_dly;
    logic [c_PIPE_LAT-1:0]  r_vs_dly;

    assign w_hs_fall = r_hs_q & ~hs_i;
    assign w_vs_fall = r_vs_q & ~vs_i;

    // Line FSM: state register / next state / outputs
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_hs_fall)      w_state_nxt = S_LINE;
        else if (w_vs_fall) w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_line_act = (r_state == S_LINE);
    end

    // Line parameters latch on the hs fall, so that cycle already uses the new ones
    assign w_cnt_cur  = w_hs_fall ? '0 : r_cnt;
    assign w_size_cur = w_hs_fall ? line_in_size : r_size;
    assign w_accept   = de_i & ~hs_i & (w_line_act | w_hs_fall)
                      & (32'(w_cnt_cur) <= 32'(w_size_cur));

    assign w_run      = w_line_act & ~w_hs_fall;
    assign w_k32      = 32'(r_pos >> c_FRAC);
    assign w_cnt32    = 32'(r_cnt);
    assign w_size32   = 32'(r_size);
    assign w_in_range = 32'(r_pos) <= (w_size32 << c_FRAC);
    assign w_repl     = (w_k32 == w_size32);
    // Pair regs hold in[cnt-2], in[cnt-1]; position k is served when cnt == k+2
    assign w_issue    = w_run & w_in_range
                      & ((w_cnt32 == w_k32 + 2) | (w_repl & (w_cnt32 == w_size32 + 1)));
    // Positions left behind by an overrun are stepped over without issuing
    assign w_skip     = w_run & (w_cnt32 > w_k32 + 2);
    assign w_pos_nxt  = (w_issue | w_skip) ? r_pos + c_POS_W'(r_step) : r_pos;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hs_q <= 1'b0;
            r_vs_q <= 1'b0;
            r_size <= '0;
            r_step <= '0;
            r_cnt  <= '0;
            r_pos  <= '0;
            r_prev <= '0;
            r_cur  <= '0;
        end else begin
            r_hs_q <= hs_i;
            r_vs_q <= vs_i;
            if (w_hs_fall) begin
                r_size <= line_in_size;
                r_step <= scale_step;
                r_pos  <= '0;
            end else begin
                r_pos  <= w_pos_nxt;
            end
            r_cnt <= w_accept ? w_cnt_cur + c_CNT_W'(1) : w_cnt_cur;
            if (w_accept) begin
                r_prev <= r_cur;
                r_cur  <= di_i;
            end
        end
    end

    assign w_coef = COE_WIDTH'(r_s1_f) << c_COE_SH;
    assign w_wa   = c_ONE - {1'b0, w_coef};
    assign w_wb   = {1'b0, w_coef};
    assign w_sum  = {1'b0, r_s2_pa} + {1'b0, r_s2_pb} + c_HALF;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_f   <= '0;
            r_s2_vld <= 1'b0;
            r_s2_pa  <= '0;
            r_s2_pb  <= '0;
            r_de     <= 1'b0;
            r_do     <= '0;
            r_hs_dly <= '1;
            r_vs_dly <= '0;
        end else begin
            r_s1_vld <= w_issue;
            r_s1_a   <= w_repl ? r_cur : r_prev;
            r_s1_b   <= r_cur;
            r_s1_f   <= r_pos[c_FRAC-1:0];
            r_s2_vld <= r_s1_vld;
            r_s2_pa  <= c_PROD_W'(r_s1_a) * c_PROD_W'(w_wa);
            r_s2_pb  <= c_PROD_W'(r_s1_b) * c_PROD_W'(w_wb);
            r_de     <= r_s2_vld;
            r_do     <= r_s2_vld ? PIXEL_WIDTH'(w_sum >> COE_WIDTH) : '0;
            r_hs_dly <= {r_hs_dly[c_PIPE_LAT-2:0], hs_i};
            r_vs_dly <= {r_vs_dly[c_PIPE_LAT-2:0], vs_i};
        end
    end

    assign do_o = r_do;
    assign de_o = r_de;
    assign hs_o = r_hs_dly[c_PIPE_LAT-1];
    assign vs_o = r_vs_dly[c_PIPE_LAT-1];

`ifdef SCALER_H_OVF_DET_EN
    logic w_ovr;
    logic w_vs_rise;
    logic r_ovf;

    // Overrun: a pixel lands while the pair still has unserved positions
    assign w_ovr     = w_run & w_accept & (32'(w_pos_nxt >> c_FRAC) + 2 <= w_cnt32);
    assign w_vs_rise = ~r_vs_q & vs_i;

    always_ff @(posedge clk) begin
        if (!rst_n)         r_ovf <= 1'b0;
        else if (w_ovr)     r_ovf <= 1'b1;
        else if (w_vs_rise) r_ovf <= 1'b0;
    end

    assign ovf_o = r_ovf;
`endif

endmodule

`default_nettype wire
